// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: general-purpose register file with NUM_RD registered
// read ports, one write port with write-through bypass, and a per-register
// pending-write (busy) scoreboard used by decode to detect RAW hazards.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  // Register 0 is hardwired when ZERO_REG is set: writes to it are dropped.
  logic wr_to_zero;
  logic wr_ok;

  assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok      = wr_en && !wr_to_zero;

  // --------------------------------------------------------------------
  // Register array
  // --------------------------------------------------------------------
  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Array write; reset clears the whole file so no stale data survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------
  // Busy scoreboard
  // --------------------------------------------------------------------
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  busy_cnt_reg;
  logic [ADDR_W:0]  busy_cnt_next;

  // Per-register next state. Issue is checked first because the issued
  // instruction is newer than any flush or writeback on the same edge.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_norm
        logic iss_hit;
        logic wr_hit;
        assign iss_hit = iss_en && (iss_addr == IDX);
        assign wr_hit  = wr_en && (wr_addr == IDX);
        assign busy_next[gi] = iss_hit ? 1'b1 :
                               flush   ? 1'b0 :
                               wr_hit  ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    busy_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_next = busy_cnt_next + (ADDR_W + 1)'(busy_next[i]);
    end
  end

  // Scoreboard state and its count update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign busy_cnt = busy_cnt_reg;

  // --------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              is_zero;
      logic              bypass;
      logic [DATA_W-1:0] data_next;
      logic [DATA_W-1:0] data_reg;

      assign addr    = rd_addr[gi*ADDR_W +: ADDR_W];
      assign is_zero = (ZERO_REG != 0) && (addr == '0);
      assign bypass  = wr_ok && (wr_addr == addr);

      // Select the value this port captures: hardwired zero, the in-flight
      // writeback data, or the array contents.
      always_comb begin
        data_next = mem_reg[addr];
        if (is_zero) begin
          data_next = '0;
        end else if (bypass) begin
          data_next = wr_data;
        end
      end

      // Registered read data, one cycle after the address.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_reg <= '0;
        end else begin
          data_reg <= data_next;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data_reg;

      // A same-cycle writeback to this address resolves the hazard because
      // the bypass supplies the data; issue and flush only act next cycle.
      assign rd_busy[gi] = busy_reg[addr] && !(wr_en && (wr_addr == addr));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed stimulus, a
// behavioural model compared every cycle, and literal spot checks.
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en = 1'b0;
  logic [ADDR_W-1:0]        wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     iss_en = 1'b0;
  logic [ADDR_W-1:0]        iss_addr = '0;
  logic                     flush = 1'b0;
  logic [ADDR_W:0]          busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_reg  [DEPTH];
  bit                m_busy [DEPTH];
  logic [DATA_W-1:0] m_rd   [NUM_RD];
  int                m_cnt;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    for (int p = 0; p < NUM_RD; p++) m_rd[p] = '0;
    m_cnt = 0;
  end

  // Reads observe the register file after this edge's write is applied,
  // which is exactly what write-through bypass provides.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
      for (int p = 0; p < NUM_RD; p++) m_rd[p] = '0;
      m_cnt = 0;
    end else begin
      if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
      for (int p = 0; p < NUM_RD; p++) begin
        int a;
        a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
        m_rd[p] = (a == 0) ? '0 : m_reg[a];
      end
      if (flush) for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      if (wr_en) m_busy[wr_addr] = 0;
      if (iss_en) m_busy[iss_addr] = 1;
      m_busy[0] = 0;
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_cnt += int'(m_busy[i]);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int p = 0; p < NUM_RD; p++) begin
      int a;
      bit eb;
      a  = int'(rd_addr[p*ADDR_W +: ADDR_W]);
      eb = m_busy[a] && !(wr_en && int'(wr_addr) == a);
      check($sformatf("model rd_data%0d", p), 64'(rd_data[p*DATA_W +: DATA_W]), 64'(m_rd[p]));
      check($sformatf("model rd_busy%0d", p), 64'(rd_busy[p]), 64'(eb));
    end
    check("model busy_cnt", 64'(busy_cnt), 64'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic we, input int wa, input logic [DATA_W-1:0] wd,
                       input logic ie, input int ia, input logic fl,
                       input int a0, input int a1);
    wr_en    = we;
    wr_addr  = ADDR_W'(wa);
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = ADDR_W'(ia);
    flush    = fl;
    rd_addr  = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset then read
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    tick();
    check("reset rd_data0", 64'(rd_data[31:0]), 64'h0);
    check("reset rd_data1", 64'(rd_data[63:32]), 64'h0);
    check("reset busy_cnt", 64'(busy_cnt), 64'd0);
    check("reset rd_busy", 64'(rd_busy), 64'b00);

    // Write with same-edge bypass, then array read
    drive(1, 3, 32'h0000_00A5, 0, 0, 0, 3, 2);
    tick();
    check("bypass rd_data0", 64'(rd_data[31:0]), 64'hA5);
    drive(0, 0, 0, 0, 0, 0, 3, 2);
    tick();
    check("array rd_data0", 64'(rd_data[31:0]), 64'hA5);

    // Zero register
    drive(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 3);
    #1 check("zero rd_busy0", 64'(rd_busy[0]), 64'd0);
    tick();
    check("zero rd_data0", 64'(rd_data[31:0]), 64'h0);
    check("zero busy_cnt", 64'(busy_cnt), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("zero rd_busy after", 64'(rd_busy), 64'b00);
    tick();

    // Scoreboard sequence
    drive(0, 0, 0, 1, 5, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 7, 0, 5, 0);
    tick();
    check("issue busy_cnt", 64'(busy_cnt), 64'd2);
    drive(0, 0, 0, 0, 0, 0, 5, 7);
    #1 check("issue rd_busy", 64'(rd_busy), 64'b11);
    tick();
    drive(1, 5, 32'h0000_1234, 0, 0, 0, 5, 7);
    #1 check("wb rd_busy0", 64'(rd_busy[0]), 64'd0);
    tick();
    check("wb rd_data0", 64'(rd_data[31:0]), 64'h1234);
    check("wb busy_cnt", 64'(busy_cnt), 64'd1);

    // Write to a non-busy register leaves it idle
    drive(1, 12, 32'hCAFE_0001, 0, 0, 0, 12, 0);
    tick();
    check("nonbusy rd_data0", 64'(rd_data[31:0]), 64'hCAFE_0001);
    check("nonbusy busy_cnt", 64'(busy_cnt), 64'd1);

    // Issue and writeback of the same register on one edge
    drive(1, 9, 32'h99, 1, 9, 0, 9, 0);
    tick();
    check("collide busy_cnt", 64'(busy_cnt), 64'd2);
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    #1 check("collide rd_busy0", 64'(rd_busy[0]), 64'd1);
    tick();

    // Flush with issue keeps only the new destination
    drive(0, 0, 0, 1, 6, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 8, 0, 0, 0);
    tick();
    check("preflush busy_cnt", 64'(busy_cnt), 64'd4);
    drive(0, 0, 0, 1, 4, 1, 6, 8);
    #1 check("flush rd_busy same cycle", 64'(rd_busy), 64'b11);
    tick();
    check("flush busy_cnt", 64'(busy_cnt), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 4, 6);
    #1 check("flush rd_busy", 64'(rd_busy), 64'b01);
    tick();

    // Fill every nonzero register, then reset asynchronously mid-cycle
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    for (int r = 1; r < DEPTH; r++) begin
      drive(0, 0, 0, 1, r, 0, 3, 12);
      tick();
    end
    check("fill busy_cnt", 64'(busy_cnt), 64'd31);
    check("fill rd_data0", 64'(rd_data[31:0]), 64'hA5);
    drive(0, 0, 0, 0, 0, 0, 3, 12);
    #2 reset = 1'b0;
    #1;
    check("async busy_cnt", 64'(busy_cnt), 64'd0);
    check("async rd_data0", 64'(rd_data[31:0]), 64'h0);
    check("async rd_data1", 64'(rd_data[63:32]), 64'h0);
    tick();
    reset = 1'b1;
    tick();
    check("post reset busy_cnt", 64'(busy_cnt), 64'd0);
    check("post reset r3", 64'(rd_data[31:0]), 64'h0);
    check("post reset rd_busy", 64'(rd_busy), 64'b00);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
